// File: rtl/uart_rom_loader.sv
// Streams a length-prefixed Hack program from an 8N1 UART into program ROM over the rom_loader_* handshake.
// Optional trailing XOR checksum byte is enabled by defining UART_ROM_LOADER_CHECKSUM_EN.
module uart_rom_loader #(
    parameter int CLK_HZ     = 25125000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 32768
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  run,
    output logic                  done_loading,
    output logic                  error,
    output logic [15:0]           words_loaded,
    output logic                  rom_loader_reset,
    output logic                  rom_loader_load,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    input  logic                  rom_loader_load_received
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      MAX_LEN   = 17'(MAX_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_LOAD, S_WAIT_ACK,
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_ERROR
    } state_t;

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift, rx_byte;
    logic             byte_valid, consume, stop_tick, byte_ok, rx_err, err_active;

    state_t           state;
    logic [15:0]      len;
    logic [7:0]       hi;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // A completed byte is rejected (framing or overrun) when the stop bit is low
    // or the previous byte is still unclaimed in the holding register.
    assign stop_tick  = (rx_state == R_STOP) && (rx_cnt == BIT_LAST);
    assign byte_ok    = stop_tick && rx_sync && (!byte_valid || consume);
    assign rx_err     = stop_tick && !byte_ok;
    assign consume    = byte_valid && !(state inside {S_RST, S_LOAD, S_WAIT_ACK});
    assign err_active = rx_err && !(state inside {S_IDLE, S_DONE, S_ERROR});

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (byte_ok) begin
                byte_valid <= 1'b1;
                rx_byte    <= rx_shift;
            end else if (consume) begin
                byte_valid <= 1'b0;
            end
            rx_cnt <= rx_cnt + 1'b1;
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) rx_state <= R_START;
                end
                R_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_sync ? R_IDLE : R_DATA;
                end
                R_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= R_STOP;
                end
                R_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            done_loading     <= 1'b0;
            error            <= 1'b0;
            words_loaded     <= '0;
            rom_loader_reset <= 1'b0;
            rom_loader_load  <= 1'b0;
            rom_loader_data  <= '0;
            len              <= '0;
            hi               <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            csum             <= '0;
`endif
        end else if (err_active) begin
            state            <= S_ERROR;
            error            <= 1'b1;
            rom_loader_load  <= 1'b0;
            rom_loader_reset <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (run) begin
                    state            <= S_RST;
                    rom_loader_reset <= 1'b1;
                end
                S_RST: begin
                    rom_loader_reset <= 1'b0;
                    words_loaded     <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                    csum             <= '0;
`endif
                    state            <= S_LEN_HI;
                end
                S_LEN_HI: if (byte_valid) begin
                    len[15:8] <= rx_byte;
                    state     <= S_LEN_LO;
                end
                S_LEN_LO: if (byte_valid) begin
                    len[7:0] <= rx_byte;
                    if ({len[15:8], rx_byte} == 16'd0) begin
                        state        <= S_DONE;
                        done_loading <= 1'b1;
                    end else if ({1'b0, len[15:8], rx_byte} > MAX_LEN) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        state <= S_W_HI;
                    end
                end
                S_W_HI: if (byte_valid) begin
                    hi    <= rx_byte;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                    csum  <= csum ^ rx_byte;
`endif
                    state <= S_W_LO;
                end
                S_W_LO: if (byte_valid) begin
                    rom_loader_data <= {hi, rx_byte};
                    rom_loader_load <= 1'b1;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                    csum            <= csum ^ rx_byte;
`endif
                    state           <= S_LOAD;
                end
                S_LOAD: if (rom_loader_load_received) begin
                    rom_loader_load <= 1'b0;
                    state           <= S_WAIT_ACK;
                end
                S_WAIT_ACK: if (rom_loader_ack) begin
                    if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 1'b1;
                    if ({1'b0, words_loaded} + 17'd1 == {1'b0, len}) begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state        <= S_DONE;
                        done_loading <= 1'b1;
`endif
                    end else begin
                        state <= S_W_HI;
                    end
                end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                S_CHK: if (byte_valid) begin
                    if (rx_byte == csum) begin
                        state        <= S_DONE;
                        done_loading <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end
                end
`endif
                S_DONE: if (!run) begin
                    state        <= S_IDLE;
                    done_loading <= 1'b0;
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: UART byte driver, ROM handshake model and a stream-level expected-result model.
module tb_uart_rom_loader;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 125000;
    localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int MAXW   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        run = 1'b0;
    logic        done_loading, error, rom_loader_reset, rom_loader_load;
    logic [15:0] words_loaded, rom_loader_data;
    logic        rom_loader_ack = 1'b0;
    logic        load_received = 1'b0;

    uart_rom_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_WIDTH(16), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .run(run),
        .done_loading(done_loading), .error(error), .words_loaded(words_loaded),
        .rom_loader_reset(rom_loader_reset), .rom_loader_load(rom_loader_load),
        .rom_loader_data(rom_loader_data), .rom_loader_ack(rom_loader_ack),
        .rom_loader_load_received(load_received)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // ROM model and handshake monitor; all counters are free-running, tests use deltas.
    int          lr_dly = 3, ack_dly = 20;
    int          rom_ph = 0, rom_cnt = 0;
    bit          outstanding = 1'b0;
    logic        prev_load = 1'b0;
    logic [15:0] prev_data = '0;
    int          loads_n = 0, rst_n = 0, mon_bad = 0;
    logic [15:0] got_q[$];

    always @(negedge clk) begin
        if (reset) begin
            rom_ph = 0; outstanding = 1'b0; prev_load = 1'b0;
            load_received = 1'b0; rom_loader_ack = 1'b0;
        end else begin
            if (rom_loader_reset) rst_n++;
            if (load_received && rom_loader_load) mon_bad++;
            if (prev_load && rom_loader_load && rom_loader_data != prev_data) mon_bad++;
            if (rom_loader_load && !prev_load) begin
                loads_n++;
                if (outstanding) mon_bad++;
            end
            prev_load = rom_loader_load;
            prev_data = rom_loader_data;
            load_received = 1'b0;
            rom_loader_ack = 1'b0;
            if (rom_ph == 0) begin
                if (rom_loader_load) begin rom_ph = 1; rom_cnt = 0; outstanding = 1'b1; end
            end else begin
                rom_cnt++;
                if (rom_ph == 1 && rom_cnt >= lr_dly) begin
                    load_received = 1'b1;
                    got_q.push_back(rom_loader_data);
                    rom_ph = 2;
                end
                if (rom_ph == 2 && (rom_cnt == ack_dly || rom_cnt == ack_dly + 1)) rom_loader_ack = 1'b1;
                if (rom_ph == 2 && rom_cnt == ack_dly + 1) begin rom_ph = 0; outstanding = 1'b0; end
            end
        end
    end

    typedef struct {
        int          nb;
        logic [95:0] bytes;
        int          bad;
        int          lr;
        int          ak;
        logic        e_done;
        logic        e_err;
        int          e_wl;
        logic [63:0] w;
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  tx_q[$];
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_all(input int bad);
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], i != bad);
    endtask

    task automatic add_csum();
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = '0;
        for (int i = 2; i < tx_q.size(); i++) x ^= tx_q[i];
        tx_q.push_back(x);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_loading || error) begin ok = 1'b1; break; end
        end
        chk("end_reached", ok, 1'b1);
    endtask

    // Sends tx_q (reset must already be done) and checks the outcome against exp_q.
    task automatic load_and_check(input int bad, input int lr, input int ak,
                                  input logic e_done, input logic e_err, input int e_wl);
        int lb, gb, rb, mb;
        lr_dly = lr; ack_dly = ak;
        lb = loads_n; gb = got_q.size(); rb = rst_n; mb = mon_bad;
        run = 1'b1;
        send_all(bad);
        wait_end(600);
        repeat (20) @(negedge clk);
        chk("done_loading", done_loading, e_done);
        chk("error", error, e_err);
        chk("words_loaded", words_loaded, e_wl);
        chk("load_count", loads_n - lb, exp_q.size());
        chk("reset_pulse_cycles", rst_n - rb, 1);
        chk("rom_words_seen", got_q.size() - gb, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (gb + k < got_q.size()) chk("rom_word", got_q[gb + k], exp_q[k]);
        chk("handshake_violations", mon_bad - mb, 0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_after_run_low", done_loading, 1'b0);
        chk("error_sticky", error, e_err);
    endtask

    initial begin
        int n, lr, ak;
        logic [15:0] wd;
        logic e_err;

        vecs[0] = '{6,  96'h0002ABCD1234_000000000000, -1, 3, 20, 1'b1, 1'b0, 2, 64'hABCD_1234_0000_0000};
        vecs[1] = '{2,  96'h0000_00000000_000000000000, -1, 3, 20, 1'b1, 1'b0, 0, 64'h0};
        vecs[2] = '{6,  96'h0002ABCD1234_000000000000,  3, 3, 20, 1'b0, 1'b1, 0, 64'h0};
        vecs[3] = '{2,  96'h0005_00000000_000000000000, -1, 3, 20, 1'b0, 1'b1, 0, 64'h0};
        vecs[4] = '{10, 96'h00041111222233334444_0000, -1, 2, 8,  1'b1, 1'b0, 4, 64'h1111_2222_3333_4444};
        vecs[5] = '{4,  96'h0001BEEF_0000000000000000, -1, 5, 5,  1'b1, 1'b0, 1, 64'hBEEF_0000_0000_0000};
        vecs[6] = '{6,  96'h000201020304_000000000000,  1, 3, 20, 1'b0, 1'b1, 0, 64'h0};

        do_reset();
        chk("rst_done_loading", done_loading, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_words_loaded", words_loaded, 16'h0);
        chk("rst_rom_loader_reset", rom_loader_reset, 1'b0);
        chk("rst_rom_loader_load", rom_loader_load, 1'b0);
        chk("rst_rom_loader_data", rom_loader_data, 16'h0);

        foreach (vecs[v]) begin
            tx_q.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].nb; i++) tx_q.push_back(vecs[v].bytes[95 - 8 * i -: 8]);
            add_csum();
            for (int k = 0; k < vecs[v].e_wl; k++) exp_q.push_back(vecs[v].w[63 - 16 * k -: 16]);
            do_reset();
            load_and_check(vecs[v].bad, vecs[v].lr, vecs[v].ak, vecs[v].e_done, vecs[v].e_err, vecs[v].e_wl);
        end

        // Randomised streams checked against the stream rules: N=0 or N<=MAX loads N words, N>MAX errors.
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(0, MAXW + 1);
            lr = $urandom_range(1, 6);
            ak = $urandom_range(lr, 25);
            e_err = (n > MAXW);
            tx_q.delete();
            exp_q.delete();
            tx_q.push_back(8'(n >> 8));
            tx_q.push_back(8'(n));
            for (int k = 0; k < n && !e_err; k++) begin
                wd = 16'($urandom);
                tx_q.push_back(wd[15:8]);
                tx_q.push_back(wd[7:0]);
                exp_q.push_back(wd);
            end
            add_csum();
            do_reset();
            load_and_check(-1, lr, ak, !e_err, e_err, exp_q.size());
        end

        // Reset while a load request is pending, then a clean reload.
        do_reset();
        lr_dly = 60; ack_dly = 80;
        run = 1'b1;
        tx_q = '{8'h00, 8'h02, 8'h11, 8'h22};
        send_all(-1);
        chk("load_before_reset", rom_loader_load, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("load_after_reset", rom_loader_load, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tx_q = '{8'h00, 8'h01, 8'h55, 8'hAA};
        add_csum();
        exp_q = '{16'h55AA};
        load_and_check(-1, 3, 20, 1'b1, 1'b0, 1);

        // Overrun: ack withheld for ~3 byte times while the stream keeps coming.
        begin
            int lb;
            do_reset();
            lr_dly = 3; ack_dly = 300;
            lb = loads_n;
            run = 1'b1;
            tx_q = '{8'h00, 8'h03, 8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
            send_all(-1);
            wait_end(400);
            repeat (350) @(negedge clk);
            chk("overrun_error", error, 1'b1);
            chk("overrun_done", done_loading, 1'b0);
            chk("overrun_loads", loads_n - lb, 1);
            chk("overrun_load_low", rom_loader_load, 1'b0);
            run = 1'b0;
        end

`ifdef UART_ROM_LOADER_CHECKSUM_EN
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'hFF};
        exp_q = '{16'h0FF0};
        load_and_check(-1, 3, 20, 1'b1, 1'b0, 1);
        do_reset();
        tx_q = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'hFE};
        load_and_check(-1, 3, 20, 1'b0, 1'b1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rom_loader.md
# uart_rom_loader

Streams a Hack program from a host over a UART RX line and writes it, word by word, into the SoC's program ROM through the `rom_loader_*` handshake of `hack_soc`. It is the serial alternative to the file-based ROM loader in the FPGA top level and drives the same control lines. `done_loading` gates `ready_to_start`, so the CPU is released only after a complete, error-free download.

## Interface
- `CLK_HZ`, 25125000: clock frequency in Hz.
- `BAUD`, 115200: UART bit rate; `CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD`.
- `DATA_WIDTH`, 16: instruction width (fixed at 16).
- `MAX_WORDS`, 32768: largest accepted program length.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  UART line, idle high, asynchronous to `clk`.
- `run`  in  1  level; starts a download when high in IDLE.
- `done_loading`  out  1  high in DONE.
- `error`  out  1  high in ERROR.
- `words_loaded`  out  16  count of words acknowledged by the ROM.
- `rom_loader_reset`  out  1  rewinds the ROM write address.
- `rom_loader_load`  out  1  write request.
- `rom_loader_data`  out  16  word to write.
- `rom_loader_ack`  in  1  ROM write completed.
- `rom_loader_load_received`  in  1  ROM has latched the request.

## Operation
- **Input synchroniser:** `rx` passes through 2 flip-flops before use.
- **UART receiver (8N1, LSB first):**
  - A falling edge starts a frame; the start bit is re-checked at its centre (`CLKS_PER_BIT/2`).
  - If the start bit is high at its centre, it is a glitch and the receiver returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT`.
  - If the stop bit is 0, the result is a framing error.
  - A good byte sets a 1-byte holding register and `byte_valid`.
  - If a byte completes while `byte_valid` is still set, the result is an overrun error.
- **Stream format:**
  - Length N: 16 bits, big-endian.
  - Then N words, each 16 bits, high byte first.
- **FSM states and transitions:**
  - IDLE: when `run`=1, go to RST.
  - RST: `rom_loader_reset`=1 for exactly 1 cycle, then go to LEN_HI.
  - LEN_HI, then LEN_LO: each consumes one byte.
    - N=0: go to DONE.
    - N>`MAX_WORDS`: go to ERROR.
    - Otherwise: go to W_HI.
  - W_HI, then W_LO: each consumes one byte.
    - After W_LO, `rom_loader_data` = {hi,lo} and the FSM goes to LOAD.
  - LOAD: `rom_loader_load`=1, data held stable.
    - On `rom_loader_load_received`=1, drop `load` and go to WAIT_ACK.
  - WAIT_ACK: on `rom_loader_ack`=1, increment `words_loaded`.
    - If `words_loaded`+1 == N: go to DONE (or CHK; see Configuration).
    - Otherwise: go to W_HI.
  - DONE: stays until `run`=0, then goes to IDLE.
  - ERROR: sticky; only `reset` clears it.
- Framing or overrun error in any non-IDLE state: go to ERROR and deassert `rom_loader_load`.
- Bytes arriving in IDLE, DONE or ERROR are discarded silently and set no error.
- `words_loaded` clears in RST and saturates at 0xFFFF.

## Timing
- **Reset values:** all outputs are 0, the FSM is in IDLE and the receiver is idle. A reset mid-transfer drops `rom_loader_load` in the cycle after the reset edge.
- **Byte latency:** `byte_valid` rises 1 cycle after the stop-bit centre sample. A consuming state clears it in that same cycle.
- **Request latency:** `rom_loader_load` rises 1 cycle after the W_LO byte is consumed.
- **Handshake:** `load` and `data` stay constant from assertion until `load_received` is sampled high. `load` is low in the following cycle. A new `load` is never raised before `ack` is seen.
- **Simultaneous events:** if `load_received` and `ack` are high in the same cycle, LOAD goes to WAIT_ACK. The ack is counted in the next cycle only if it is still high.
- **Overlap with the ROM write:** bytes keep arriving during LOAD/WAIT_ACK and are held in the holding register. The ROM write must finish within one byte time (10·`CLKS_PER_BIT`) or an overrun error results.

## Configuration
- `UART_ROM_LOADER_CHECKSUM_EN` defined:
  - After the last ack, the FSM enters CHK and consumes 1 byte.
  - That byte must equal the XOR of all payload bytes, length bytes excluded.
  - Match: go to DONE. Mismatch: go to ERROR.
- Not defined: the CHK state is absent and the last ack goes directly to DONE.

## Test plan
- Test 1, basic load:
  - Stimulus: reset, `run`=1, stream 00 02 AB CD 12 34; the ROM model gives `load_received` after 3 cycles and `ack` after 20.
  - Required: 2 loads with data 0xABCD then 0x1234, `rom_loader_reset` pulses exactly once, `words_loaded`=2, `done_loading`=1, `error`=0.
- Test 2, zero length:
  - Stimulus: stream 00 00.
  - Required: no `rom_loader_load`, DONE reached, `words_loaded`=0.
- Test 3, framing error:
  - Stimulus: send the second data byte with stop bit 0.
  - Required: `error`=1, `load` stays low, `done_loading` stays 0 until reset.
- Test 4, overrun:
  - Stimulus: the ROM model withholds `ack` for 3 byte times while bytes keep streaming.
  - Required: `error`=1, and `load` is not re-asserted.
- Test 5, reset mid-transfer:
  - Stimulus: assert `reset` while `load`=1, then reload 00 01 55 AA.
  - Required: `load`=0 the cycle after reset, then a clean load of 0x55AA with `done_loading`=1.
- Test 6, checksum (`UART_ROM_LOADER_CHECKSUM_EN` defined):
  - Stimulus: 00 01 0F F0 followed by checksum FF.
  - Required: DONE.
  - Stimulus: same stream with checksum FE.
  - Required: ERROR after the word is written.
